// File: rtl/conv_frame_sequencer_if.sv
// Handshake and status bundle between the input stream, the line buffers and the
// sliding-window output stage of the convolution frame sequencer.
interface conv_frame_sequencer_if #(
    parameter int DIM_WIDTH  = 14,
    parameter int LINE_SEL_W = 2
);
    logic [DIM_WIDTH-1:0]  cfg_width;
    logic [DIM_WIDTH-1:0]  cfg_height;
    logic                  s_valid;
    logic                  s_ready;
    logic                  s_user;
    logic                  s_last;
    logic                  m_ready;
    logic                  buf_we;
    logic [DIM_WIDTH-1:0]  buf_wr_addr;
    logic [LINE_SEL_W-1:0] buf_line_sel;
    logic                  buf_eol;
    logic                  out_valid;
    logic                  out_user;
    logic                  out_last;
    logic                  busy;
    logic                  frame_done;
    logic                  err_len;
    logic                  err_sof;
    logic                  err_cfg;

    modport master (
        output cfg_width, cfg_height, s_valid, s_user, s_last, m_ready,
        input  s_ready, buf_we, buf_wr_addr, buf_line_sel, buf_eol,
        input  out_valid, out_user, out_last, busy, frame_done,
        input  err_len, err_sof, err_cfg
    );

    modport slave (
        input  cfg_width, cfg_height, s_valid, s_user, s_last, m_ready,
        output s_ready, buf_we, buf_wr_addr, buf_line_sel, buf_eol,
        output out_valid, out_user, out_last, busy, frame_done,
        output err_len, err_sof, err_cfg
    );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Row/column sequencer for the convolution line buffers: drives buffer writes and
// tags pixels that complete a full kernel window, delayed to match the window output.
module conv_frame_sequencer #(
    parameter int DIM_WIDTH     = 14,
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int NUM_LINES     = 3,
    parameter int PIPE_LATENCY  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    conv_frame_sequencer_if.slave  io_bus
);
    localparam int LSW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int CW  = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

    localparam logic [DIM_WIDTH-1:0] KW    = DIM_WIDTH'(KERNEL_WIDTH);
    localparam logic [DIM_WIDTH-1:0] KH    = DIM_WIDTH'(KERNEL_HEIGHT);
    localparam logic [DIM_WIDTH-1:0] KW_M1 = DIM_WIDTH'(KERNEL_WIDTH - 1);
    localparam logic [DIM_WIDTH-1:0] KH_M1 = DIM_WIDTH'(KERNEL_HEIGHT - 1);
    localparam logic [LSW-1:0]       LINE_LAST = LSW'(NUM_LINES - 1);
    localparam logic [CW-1:0]        CNT_LAST  = CW'(PIPE_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [DIM_WIDTH-1:0]   r_col;
    logic [DIM_WIDTH-1:0]   r_row;
    logic [DIM_WIDTH-1:0]   r_w_m1;
    logic [DIM_WIDTH-1:0]   r_h_m1;
    logic [LSW-1:0]         r_line;
    logic [CW-1:0]          r_drain_cnt;
    logic [2:0]             r_dly [PIPE_LATENCY];
    logic                   r_busy;
    logic                   r_frame_done;
    logic                   r_err_len;
    logic                   r_err_sof;
    logic                   r_err_cfg;

    logic                   w_s_ready;
    logic                   w_acc;
    logic                   w_cfg_ok;
    logic                   w_start;
    logic                   w_start_ok;
    logic                   w_px;
    logic                   w_col_end;
    logic                   w_eol;
    logic                   w_last_row;
    logic                   w_win;
    logic                   w_first;
    logic                   w_wlast;
    logic                   w_len_err;
    logic                   w_sof_err;
    logic                   w_cfg_err;
    logic [LSW-1:0]         w_line_next;
    logic [CW-1:0]          w_cnt_inc;

    // Accept decode, line-end detection and window tagging for the current beat
    always_comb begin
        w_s_ready  = io_bus.m_ready && ((r_state == ST_IDLE) || (r_state == ST_ACTIVE));
        w_acc      = io_bus.s_valid && w_s_ready;
        w_cfg_ok   = (io_bus.cfg_width >= KW) && (io_bus.cfg_height >= KH);
        w_start    = w_acc && io_bus.s_user;
        w_start_ok = w_start && w_cfg_ok;
        // An SOF beat always restarts the frame, so it never counts as a mid-line pixel
        w_px       = w_acc && (r_state == ST_ACTIVE) && !io_bus.s_user;
        w_col_end  = (r_col == r_w_m1);
        w_eol      = w_px && (w_col_end || io_bus.s_last);
        w_last_row = (r_row == r_h_m1);
        w_win      = w_px && (r_row >= KH_M1) && (r_col >= KW_M1);
        w_first    = w_px && (r_row == KH_M1) && (r_col == KW_M1);
        w_wlast    = w_win && w_eol;
        w_len_err  = w_px && (w_col_end != io_bus.s_last);
        w_sof_err  = w_acc && (((r_state == ST_IDLE) && !io_bus.s_user) ||
                               ((r_state == ST_ACTIVE) && io_bus.s_user));
        w_cfg_err  = w_start && !w_cfg_ok;
        w_cnt_inc  = r_drain_cnt + CW'(1);
        if (r_line == LINE_LAST) begin
            w_line_next = '0;
        end else begin
            w_line_next = r_line + LSW'(1);
        end
    end

    // Frame FSM, position counters, window delay line and sticky error flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_w_m1       <= '0;
            r_h_m1       <= '0;
            r_line       <= '0;
            r_drain_cnt  <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_len    <= 1'b0;
            r_err_sof    <= 1'b0;
            r_err_cfg    <= 1'b0;
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                r_dly[i] <= 3'b000;
            end
        end else begin
            r_frame_done <= 1'b0;
            r_err_len    <= r_err_len | w_len_err;
            r_err_sof    <= r_err_sof | w_sof_err;
            r_err_cfg    <= r_err_cfg | w_cfg_err;
            r_dly[0]     <= {w_win, w_first, w_wlast};
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end

            if (w_start_ok) begin
                r_state <= ST_ACTIVE;
                r_busy  <= 1'b1;
                r_w_m1  <= io_bus.cfg_width - DIM_WIDTH'(1);
                r_h_m1  <= io_bus.cfg_height - DIM_WIDTH'(1);
                r_col   <= DIM_WIDTH'(1);
                r_row   <= '0;
                r_line  <= '0;
            end else if (w_start) begin
                // Bad geometry on an SOF abandons any frame in progress
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_busy <= 1'b0;
                    end
                    ST_ACTIVE: begin
                        if (w_px) begin
                            if (w_eol && w_last_row) begin
                                r_state      <= ST_DRAIN;
                                r_drain_cnt  <= '0;
                                r_frame_done <= (PIPE_LATENCY == 1);
                            end else if (w_eol) begin
                                r_col  <= '0;
                                r_row  <= r_row + DIM_WIDTH'(1);
                                r_line <= w_line_next;
                            end else begin
                                r_col <= r_col + DIM_WIDTH'(1);
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (r_drain_cnt == CNT_LAST) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_drain_cnt  <= w_cnt_inc;
                            r_frame_done <= (w_cnt_inc == CNT_LAST);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_bus.s_ready      = w_s_ready;
    assign io_bus.buf_we       = w_start_ok || w_px;
    assign io_bus.buf_wr_addr  = w_start_ok ? '0 : r_col;
    assign io_bus.buf_line_sel = w_start_ok ? '0 : r_line;
    assign io_bus.buf_eol      = w_eol;
    assign io_bus.out_valid    = r_dly[PIPE_LATENCY-1][2];
    assign io_bus.out_user     = r_dly[PIPE_LATENCY-1][1];
    assign io_bus.out_last     = r_dly[PIPE_LATENCY-1][0];
    assign io_bus.busy         = r_busy;
    assign io_bus.frame_done   = r_frame_done;
    assign io_bus.err_len      = r_err_len;
    assign io_bus.err_sof      = r_err_sof;
    assign io_bus.err_cfg      = r_err_cfg;
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer: W=5/H=4 frames with a 3x3 kernel,
// line-length, SOF and cfg errors, and reset during ACTIVE and DRAIN.
module tb_conv_frame_sequencer;
    localparam int DW  = 14;
    localparam int LSW = 2;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_frame_sequencer_if #(.DIM_WIDTH(DW), .LINE_SEL_W(LSW)) io();

    conv_frame_sequencer #(
        .DIM_WIDTH(DW), .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3),
        .NUM_LINES(3), .PIPE_LATENCY(LAT)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .io_bus (io.slave)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int mir_bad = 0;
    int d0 = 0;
    logic tgl = 1'b0;
    logic mir_chk = 1'b0;
    logic [16:0] wq [$];
    logic [1:0]  oq [$];

    // Observe buffer writes, window results, accepts and frame_done mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (io.buf_we === 1'b1) wq.push_back({io.buf_eol, io.buf_line_sel, io.buf_wr_addr});
        if (io.out_valid === 1'b1) oq.push_back({io.out_user, io.out_last});
        if (io.s_valid && io.s_ready) last_acc = cyc;
        if (io.frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mir_chk && (io.s_ready !== io.m_ready)) mir_bad++;
    end

    // Optional m_ready toggling for the backpressure frame
    always @(posedge clk) begin
        #1;
        if (tgl) io.m_ready = ~io.m_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int f_addr(input logic [16:0] e);
        return int'(e[13:0]);
    endfunction

    function automatic int f_line(input logic [16:0] e);
        return int'(e[15:14]);
    endfunction

    task automatic send_px(input logic u, input logic l);
        int n;
        n = 0;
        io.s_valid = 1'b1;
        io.s_user  = u;
        io.s_last  = l;
        @(negedge clk);
        while (!io.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        io.s_valid = 1'b0;
        io.s_user  = 1'b0;
        io.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                send_px((r == 0) && (c == 0), c == w - 1);
                if ((r == 0) && (c == 0)) mir_chk = tgl;
            end
        end
        mir_chk = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(done_cnt != base), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wq.delete();
        oq.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_clean(input string t, input int base);
        chk({t, "_we_cnt"}, wq.size(), 32'd20);
        for (int i = 0; i < 20 && i < wq.size(); i++) begin
            chk($sformatf("%s_addr%0d", t, i), f_addr(wq[i]), i % 5);
            chk($sformatf("%s_line%0d", t, i), f_line(wq[i]), (i / 5) % 3);
            chk($sformatf("%s_eol%0d", t, i), wq[i][16], 32'(i % 5 == 4));
        end
        chk({t, "_ov_cnt"}, oq.size(), 32'd6);
        for (int i = 0; i < 6 && i < oq.size(); i++) begin
            chk($sformatf("%s_user%0d", t, i), oq[i][1], 32'(i == 0));
            chk($sformatf("%s_last%0d", t, i), oq[i][0], 32'((i == 2) || (i == 5)));
        end
        chk({t, "_done_lat"}, done_cyc - last_acc, LAT);
        chk({t, "_done_cnt"}, done_cnt - base, 32'd1);
        chk({t, "_busy_after"}, io.busy, 32'd0);
    endtask

    initial begin
        io.cfg_width  = 14'd5;
        io.cfg_height = 14'd4;
        io.s_valid    = 1'b0;
        io.s_user     = 1'b0;
        io.s_last     = 1'b0;
        io.m_ready    = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", io.busy, 32'd0);
        chk("rst_done", io.frame_done, 32'd0);
        chk("rst_ov", io.out_valid, 32'd0);
        chk("rst_ou", io.out_user, 32'd0);
        chk("rst_ol", io.out_last, 32'd0);
        chk("rst_we", io.buf_we, 32'd0);
        chk("rst_elen", io.err_len, 32'd0);
        chk("rst_esof", io.err_sof, 32'd0);
        chk("rst_ecfg", io.err_cfg, 32'd0);
        rst = 1'b0;

        // Clean frame, m_ready held high
        clr();
        d0 = done_cnt;
        send_frame(5, 4);
        @(negedge clk);
        chk("drain_sready", io.s_ready, 32'd0);
        chk("drain_busy", io.busy, 32'd1);
        wait_done(d0);
        check_clean("clean", d0);
        chk("clean_elen", io.err_len, 32'd0);
        chk("clean_esof", io.err_sof, 32'd0);
        chk("clean_ecfg", io.err_cfg, 32'd0);

        // Same frame with m_ready toggling every cycle
        clr();
        d0 = done_cnt;
        mir_bad = 0;
        tgl = 1'b1;
        send_frame(5, 4);
        tgl = 1'b0;
        io.m_ready = 1'b1;
        wait_done(d0);
        check_clean("tgl", d0);
        chk("tgl_mirror", mir_bad, 32'd0);

        // Long row 0 without s_last, short row 1 ending at col 2
        pulse_reset();
        clr();
        d0 = done_cnt;
        for (int c = 0; c < 5; c++) send_px(c == 0, 1'b0);
        chk("long_elen", io.err_len, 32'd1);
        chk("long_esof", io.err_sof, 32'd0);
        for (int c = 0; c < 3; c++) send_px(1'b0, c == 2);
        for (int r = 2; r < 4; r++) begin
            for (int c = 0; c < 5; c++) send_px(1'b0, c == 4);
        end
        wait_done(d0);
        chk("len_we_cnt", wq.size(), 32'd18);
        if (wq.size() == 18) begin
            chk("long_eol", wq[4][16], 32'd1);
            chk("long_eaddr", f_addr(wq[4]), 32'd4);
            chk("row1_addr", f_addr(wq[5]), 32'd0);
            chk("row1_line", f_line(wq[5]), 32'd1);
            chk("short_eol", wq[7][16], 32'd1);
            chk("short_addr", f_addr(wq[7]), 32'd2);
            chk("row2_addr", f_addr(wq[8]), 32'd0);
            chk("row2_line", f_line(wq[8]), 32'd2);
        end
        chk("len_ov_cnt", oq.size(), 32'd6);

        // SOF arriving at row 2 col 1 restarts the frame
        pulse_reset();
        clr();
        d0 = done_cnt;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 5; c++) send_px((r == 0) && (c == 0), c == 4);
        end
        send_px(1'b0, 1'b0);
        send_px(1'b1, 1'b0);
        chk("msof_esof", io.err_sof, 32'd1);
        chk("msof_we_cnt", wq.size(), 32'd12);
        if (wq.size() == 12) begin
            chk("msof_addr", f_addr(wq[11]), 32'd0);
            chk("msof_line", f_line(wq[11]), 32'd0);
        end
        for (int c = 1; c < 5; c++) send_px(1'b0, c == 4);
        if (wq.size() >= 13) chk("msof_next_addr", f_addr(wq[12]), 32'd1);
        for (int r = 1; r < 4; r++) begin
            for (int c = 0; c < 5; c++) send_px(1'b0, c == 4);
        end
        wait_done(d0);
        chk("msof_ov_cnt", oq.size(), 32'd6);
        chk("msof_done", done_cnt - d0, 32'd1);
        chk("msof_elen", io.err_len, 32'd0);

        // Non-SOF pixel while idle is dropped
        pulse_reset();
        clr();
        send_px(1'b0, 1'b0);
        chk("idle_we_cnt", wq.size(), 32'd0);
        chk("idle_esof", io.err_sof, 32'd1);
        chk("idle_busy", io.busy, 32'd0);

        // Undersized width rejected, then a good frame
        pulse_reset();
        clr();
        io.cfg_width = 14'd2;
        send_px(1'b1, 1'b0);
        chk("cfg_ecfg", io.err_cfg, 32'd1);
        chk("cfg_busy", io.busy, 32'd0);
        chk("cfg_we_cnt", wq.size(), 32'd0);
        chk("cfg_esof", io.err_sof, 32'd0);
        io.cfg_width = 14'd5;
        d0 = done_cnt;
        send_frame(5, 4);
        wait_done(d0);
        check_clean("cfgok", d0);
        chk("cfg_sticky", io.err_cfg, 32'd1);

        // Reset in ACTIVE at row 2 with a window result in flight
        clr();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 5; c++) send_px((r == 0) && (c == 0), c == 4);
        end
        for (int c = 0; c < 3; c++) send_px(1'b0, 1'b0);
        chk("ract_busy_pre", io.busy, 32'd1);
        pulse_reset();
        chk("ract_busy", io.busy, 32'd0);
        chk("ract_ecfg", io.err_cfg, 32'd0);
        chk("ract_ov", io.out_valid, 32'd0);
        chk("ract_done", io.frame_done, 32'd0);
        clr();
        d0 = done_cnt;
        repeat (6) @(negedge clk);
        chk("ract_ov_cnt", oq.size(), 32'd0);
        chk("ract_no_done", done_cnt - d0, 32'd0);
        @(posedge clk);
        #1;

        // Reset during DRAIN
        send_px(1'b0, 1'b0);
        clr();
        send_frame(5, 4);
        @(posedge clk);
        #1;
        chk("rdrn_busy_pre", io.busy, 32'd1);
        pulse_reset();
        chk("rdrn_busy", io.busy, 32'd0);
        chk("rdrn_esof", io.err_sof, 32'd0);
        chk("rdrn_done", io.frame_done, 32'd0);
        chk("rdrn_ov", io.out_valid, 32'd0);
        clr();
        d0 = done_cnt;
        repeat (6) @(negedge clk);
        chk("rdrn_ov_cnt", oq.size(), 32'd0);
        chk("rdrn_no_done", done_cnt - d0, 32'd0);
        @(posedge clk);
        #1;

        // Clean frame after reset behaves normally
        clr();
        d0 = done_cnt;
        send_frame(5, 4);
        wait_done(d0);
        check_clean("post", d0);
        chk("post_elen", io.err_len, 32'd0);
        chk("post_esof", io.err_sof, 32'd0);
        chk("post_ecfg", io.err_cfg, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
